// File: rtl/regfile_hilo.sv
// Purpose: 32x32 GPR file with HI/LO pair, write-through read bypass,
//          GPR write-commit counter and registered write-trace outputs.
// Latency: reads 0 cycles (combinational); writes, counter and trace update on posedge clk.
// Backpressure: none; every enabled write commits in the cycle it is presented.
//
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   wb_reg_write_*           - GPR write port (data/addr/en) from MEM/WB
//   wb_hi/lo_write_data,
//   wb_hilo_write_en         - joint HI/LO write port
//   reg1/2_read_en/addr/data - two independent combinational GPR read ports
//   hi_read_data, lo_read_data - combinational HI/LO read with bypass
//   commit_cnt               - count of effective GPR writes (wraps)
//   debug_wb_rf_*            - registered write trace (strobe, number, data)
module regfile_hilo #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          wb_reg_write_data,
  input  logic [4:0]           wb_reg_write_addr,
  input  logic                 wb_reg_write_en,
  input  logic [31:0]          wb_hi_write_data,
  input  logic [31:0]          wb_lo_write_data,
  input  logic                 wb_hilo_write_en,
  input  logic                 reg1_read_en,
  input  logic [4:0]           reg1_read_addr,
  input  logic                 reg2_read_en,
  input  logic [4:0]           reg2_read_addr,
  output logic [31:0]          reg1_read_data,
  output logic [31:0]          reg2_read_data,
  output logic [31:0]          hi_read_data,
  output logic [31:0]          lo_read_data,
  output logic [CNT_WIDTH-1:0] commit_cnt,
  output logic [3:0]           debug_wb_rf_wen,
  output logic [4:0]           debug_wb_rf_wnum,
  output logic [31:0]          debug_wb_rf_wdata
);

  logic [31:0] gpr [0:31];
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  // A GPR write is effective only outside reset and never to r0; the same
  // qualifier drives storage, the commit counter and the trace strobe.
  logic wr_commit;
  assign wr_commit = wb_reg_write_en && !rst && (wb_reg_write_addr != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        gpr[i] <= 32'd0;
      end
      hi_q              <= 32'd0;
      lo_q              <= 32'd0;
      commit_cnt        <= '0;
      debug_wb_rf_wen   <= 4'b0000;
      debug_wb_rf_wnum  <= 5'd0;
      debug_wb_rf_wdata <= 32'd0;
    end else begin
      if (wr_commit) begin
        gpr[wb_reg_write_addr] <= wb_reg_write_data;
        commit_cnt             <= commit_cnt + CNT_WIDTH'(1);
        debug_wb_rf_wnum       <= wb_reg_write_addr;
        debug_wb_rf_wdata      <= wb_reg_write_data;
      end
      // Trace number/data hold their last committed values when idle.
      debug_wb_rf_wen <= {4{wr_commit}};
      if (wb_hilo_write_en) begin
        hi_q <= wb_hi_write_data;
        lo_q <= wb_lo_write_data;
      end
    end
  end

  // Read port 1: zero-forcing beats the bypass, bypass beats storage.
  always_comb begin
    reg1_read_data = 32'd0;
    if (rst || !reg1_read_en || (reg1_read_addr == 5'd0)) begin
      reg1_read_data = 32'd0;
    end else if (wb_reg_write_en && (wb_reg_write_addr == reg1_read_addr)) begin
      reg1_read_data = wb_reg_write_data;
    end else begin
      reg1_read_data = gpr[reg1_read_addr];
    end
  end

  // Read port 2: identical logic, independent enable/address.
  always_comb begin
    reg2_read_data = 32'd0;
    if (rst || !reg2_read_en || (reg2_read_addr == 5'd0)) begin
      reg2_read_data = 32'd0;
    end else if (wb_reg_write_en && (wb_reg_write_addr == reg2_read_addr)) begin
      reg2_read_data = wb_reg_write_data;
    end else begin
      reg2_read_data = gpr[reg2_read_addr];
    end
  end

  // HI/LO read with same-cycle bypass of the joint write.
  always_comb begin
    hi_read_data = hi_q;
    lo_read_data = lo_q;
    if (rst) begin
      hi_read_data = 32'd0;
      lo_read_data = 32'd0;
    end else if (wb_hilo_write_en) begin
      hi_read_data = wb_hi_write_data;
      lo_read_data = wb_lo_write_data;
    end
  end

endmodule

// File: tb/tb_regfile_hilo.sv
module tb_regfile_hilo;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   wb_reg_write_data;
  logic [4:0]    wb_reg_write_addr;
  logic          wb_reg_write_en;
  logic [31:0]   wb_hi_write_data;
  logic [31:0]   wb_lo_write_data;
  logic          wb_hilo_write_en;
  logic          reg1_read_en;
  logic [4:0]    reg1_read_addr;
  logic          reg2_read_en;
  logic [4:0]    reg2_read_addr;
  logic [31:0]   reg1_read_data;
  logic [31:0]   reg2_read_data;
  logic [31:0]   hi_read_data;
  logic [31:0]   lo_read_data;
  logic [CW-1:0] commit_cnt;
  logic [3:0]    debug_wb_rf_wen;
  logic [4:0]    debug_wb_rf_wnum;
  logic [31:0]   debug_wb_rf_wdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_hilo #(.CNT_WIDTH(CW)) dut (
    .clk               (clk),
    .rst               (rst),
    .wb_reg_write_data (wb_reg_write_data),
    .wb_reg_write_addr (wb_reg_write_addr),
    .wb_reg_write_en   (wb_reg_write_en),
    .wb_hi_write_data  (wb_hi_write_data),
    .wb_lo_write_data  (wb_lo_write_data),
    .wb_hilo_write_en  (wb_hilo_write_en),
    .reg1_read_en      (reg1_read_en),
    .reg1_read_addr    (reg1_read_addr),
    .reg2_read_en      (reg2_read_en),
    .reg2_read_addr    (reg2_read_addr),
    .reg1_read_data    (reg1_read_data),
    .reg2_read_data    (reg2_read_data),
    .hi_read_data      (hi_read_data),
    .lo_read_data      (lo_read_data),
    .commit_cnt        (commit_cnt),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        hwe;
    logic [31:0] hd;
    logic [31:0] ld;
    logic        e1;
    logic [4:0]  a1;
    logic        e2;
    logic [4:0]  a2;
    logic [31:0] x1;     // expected port 1, same cycle
    logic [31:0] x2;     // expected port 2, same cycle
    logic [31:0] xh;     // expected hi, same cycle
    logic [31:0] xl;     // expected lo, same cycle
    logic [3:0]  xcnt;   // expected commit_cnt after the edge
    logic [3:0]  xwen;   // expected trace strobe after the edge
    logic [4:0]  xwnum;
    logic [31:0] xwdata;
  } vec_t;

  vec_t tv[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    wb_reg_write_en   = 1'b0;
    wb_reg_write_addr = 5'd0;
    wb_reg_write_data = 32'd0;
    wb_hilo_write_en  = 1'b0;
    wb_hi_write_data  = 32'd0;
    wb_lo_write_data  = 32'd0;
    reg1_read_en      = 1'b0;
    reg1_read_addr    = 5'd0;
    reg2_read_en      = 1'b0;
    reg2_read_addr    = 5'd0;
  endtask

  task automatic set_write(input logic [4:0] a, input logic [31:0] d);
    wb_reg_write_en   = 1'b1;
    wb_reg_write_addr = a;
    wb_reg_write_data = d;
  endtask

  task automatic set_read(input logic [4:0] a1, input logic [4:0] a2);
    reg1_read_en   = 1'b1;
    reg1_read_addr = a1;
    reg2_read_en   = 1'b1;
    reg2_read_addr = a2;
  endtask

  // Advance through one rising edge; return 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //             we wa     wd            hwe hd            ld            e1 a1     e2 a2     x1            x2            xh            xl            cnt  wen   wnum   wdata
    tv[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 32'h0,        32'h0,        1'b1, 5'd5, 1'b1, 5'd0, 32'hDEADBEEF, 32'h0,        32'h0,        32'h0,        4'd1, 4'hF, 5'd5, 32'hDEADBEEF};
    tv[1] = '{1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        32'h0,        1'b1, 5'd5, 1'b1, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        32'h0,        4'd1, 4'h0, 5'd5, 32'hDEADBEEF};
    tv[2] = '{1'b1, 5'd7, 32'h12345678, 1'b0, 32'h0,        32'h0,        1'b1, 5'd7, 1'b1, 5'd8, 32'h12345678, 32'h0,        32'h0,        32'h0,        4'd2, 4'hF, 5'd7, 32'h12345678};
    tv[3] = '{1'b1, 5'd9, 32'hCAFEF00D, 1'b0, 32'h0,        32'h0,        1'b0, 5'd9, 1'b1, 5'd7, 32'h0,        32'h12345678, 32'h0,        32'h0,        4'd3, 4'hF, 5'd9, 32'hCAFEF00D};
    tv[4] = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 32'h0,        32'h0,        1'b1, 5'd0, 1'b1, 5'd5, 32'h0,        32'hDEADBEEF, 32'h0,        32'h0,        4'd3, 4'h0, 5'd9, 32'hCAFEF00D};
    tv[5] = '{1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        32'h0,        1'b1, 5'd0, 1'b1, 5'd9, 32'h0,        32'hCAFEF00D, 32'h0,        32'h0,        4'd3, 4'h0, 5'd9, 32'hCAFEF00D};
    tv[6] = '{1'b1, 5'd3, 32'h00000033, 1'b1, 32'hAAAA0000, 32'h0000BBBB, 1'b1, 5'd3, 1'b1, 5'd7, 32'h00000033, 32'h12345678, 32'hAAAA0000, 32'h0000BBBB, 4'd4, 4'hF, 5'd3, 32'h00000033};
    tv[7] = '{1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        32'h0,        1'b1, 5'd3, 1'b1, 5'd3, 32'h00000033, 32'h00000033, 32'hAAAA0000, 32'h0000BBBB, 4'd4, 4'h0, 5'd3, 32'h00000033};
    tv[8] = '{1'b0, 5'd3, 32'h00000BAD, 1'b1, 32'h11111111, 32'h22222222, 1'b1, 5'd3, 1'b1, 5'd9, 32'h00000033, 32'hCAFEF00D, 32'h11111111, 32'h22222222, 4'd4, 4'h0, 5'd3, 32'h00000033};
    tv[9] = '{1'b1, 5'd5, 32'h5555AAAA, 1'b0, 32'h0,        32'h0,        1'b1, 5'd5, 1'b1, 5'd5, 32'h5555AAAA, 32'h5555AAAA, 32'h11111111, 32'h22222222, 4'd5, 4'hF, 5'd5, 32'h5555AAAA};

    // Reset for two cycles with writes presented; they must be dropped.
    idle_inputs();
    rst = 1'b1;
    #1;
    for (int c = 0; c < 2; c++) begin
      set_write(5'd4, 32'h44444444);
      wb_hilo_write_en = 1'b1;
      wb_hi_write_data = 32'h99999999;
      wb_lo_write_data = 32'h88888888;
      set_read(5'd4, 5'd4);
      #2;
      chk("rst_rd1", reg1_read_data, 32'h0);
      chk("rst_hi", hi_read_data, 32'h0);
      tick();
    end
    rst = 1'b0;
    idle_inputs();
    #1;
    chk("rst_cnt", 32'(commit_cnt), 32'h0);
    chk("rst_wen", 32'(debug_wb_rf_wen), 32'h0);
    chk("rst_wnum", 32'(debug_wb_rf_wnum), 32'h0);
    chk("rst_wdata", debug_wb_rf_wdata, 32'h0);
    chk("rst_hi_q", hi_read_data, 32'h0);
    chk("rst_lo_q", lo_read_data, 32'h0);
    for (int a = 1; a < 32; a++) begin
      set_read(5'(a), 5'(a));
      #1;
      chk($sformatf("rst_r%0d_p1", a), reg1_read_data, 32'h0);
      chk($sformatf("rst_r%0d_p2", a), reg2_read_data, 32'h0);
    end
    idle_inputs();
    tick();

    // Table-driven main function.
    for (int i = 0; i < 10; i++) begin
      wb_reg_write_en   = tv[i].we;
      wb_reg_write_addr = tv[i].wa;
      wb_reg_write_data = tv[i].wd;
      wb_hilo_write_en  = tv[i].hwe;
      wb_hi_write_data  = tv[i].hd;
      wb_lo_write_data  = tv[i].ld;
      reg1_read_en      = tv[i].e1;
      reg1_read_addr    = tv[i].a1;
      reg2_read_en      = tv[i].e2;
      reg2_read_addr    = tv[i].a2;
      #2;
      chk($sformatf("v%0d_rd1", i), reg1_read_data, tv[i].x1);
      chk($sformatf("v%0d_rd2", i), reg2_read_data, tv[i].x2);
      chk($sformatf("v%0d_hi", i), hi_read_data, tv[i].xh);
      chk($sformatf("v%0d_lo", i), lo_read_data, tv[i].xl);
      tick();
      chk($sformatf("v%0d_cnt", i), 32'(commit_cnt), 32'(tv[i].xcnt));
      chk($sformatf("v%0d_wen", i), 32'(debug_wb_rf_wen), 32'(tv[i].xwen));
      chk($sformatf("v%0d_wnum", i), 32'(debug_wb_rf_wnum), 32'(tv[i].xwnum));
      chk($sformatf("v%0d_wdata", i), debug_wb_rf_wdata, tv[i].xwdata);
    end

    // Mid-stream reset: write to r2 in the reset cycle, all state cleared.
    idle_inputs();
    rst = 1'b1;
    set_write(5'd2, 32'h22220000);
    tick();
    rst = 1'b0;
    idle_inputs();
    set_read(5'd2, 5'd5);
    #1;
    chk("mid_rst_r2", reg1_read_data, 32'h0);
    chk("mid_rst_r5", reg2_read_data, 32'h0);
    chk("mid_rst_hi", hi_read_data, 32'h0);
    chk("mid_rst_cnt", 32'(commit_cnt), 32'h0);
    chk("mid_rst_wnum", 32'(debug_wb_rf_wnum), 32'h0);

    // 16 writes to r1 wrap the 4-bit counter back to 0.
    for (int k = 0; k < 16; k++) begin
      set_write(5'd1, 32'(k));
      tick();
      chk($sformatf("wrap_cnt%0d", k), 32'(commit_cnt), 32'((k + 1) % 16));
    end
    idle_inputs();
    set_read(5'd1, 5'd1);
    #1;
    chk("wrap_r1", reg1_read_data, 32'd15);

    // Reset asserted during a write to r2.
    rst = 1'b1;
    set_write(5'd2, 32'hABCDABCD);
    tick();
    rst = 1'b0;
    idle_inputs();
    set_read(5'd2, 5'd1);
    #1;
    chk("wrap_rst_r2", reg1_read_data, 32'h0);
    chk("wrap_rst_r1", reg2_read_data, 32'h0);
    chk("wrap_rst_cnt", 32'(commit_cnt), 32'h0);
    chk("wrap_rst_wen", 32'(debug_wb_rf_wen), 32'h0);

    // Writes after reset behave as from power-up.
    set_write(5'd6, 32'h00006666);
    tick();
    idle_inputs();
    set_read(5'd6, 5'd6);
    #1;
    chk("post_rst_r6", reg1_read_data, 32'h00006666);
    chk("post_rst_cnt", 32'(commit_cnt), 32'h1);
    chk("post_rst_wen", 32'(debug_wb_rf_wen), 32'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_hilo.md
REGFILE_HILO -- requirements
Module: regfile_hilo

Interface
REQ-001 Parameter CNT_WIDTH, default 32: width of the write-commit counter.
REQ-002 clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset; synchronous and active-high.
REQ-004 wb_reg_write_data  in  32  GPR write data from the MEM/WB stage.
REQ-005 wb_reg_write_addr  in  5  GPR write address.
REQ-006 wb_reg_write_en  in  1  GPR write enable.
REQ-007 wb_hi_write_data  in  32  HI write data.
REQ-008 wb_lo_write_data  in  32  LO write data.
REQ-009 wb_hilo_write_en  in  1  HI/LO joint write enable.
REQ-010 reg1_read_en, reg2_read_en  in  1 each  read-port enables.
REQ-011 reg1_read_addr, reg2_read_addr  in  5 each  read-port addresses.
REQ-012 reg1_read_data, reg2_read_data  out  32 each  read data, combinational.
REQ-013 hi_read_data, lo_read_data  out  32 each  HI/LO read data, combinational.
REQ-014 commit_cnt  out  CNT_WIDTH  count of effective GPR writes, registered.
REQ-015 debug_wb_rf_wen  out  4  registered trace write strobe.
REQ-016 debug_wb_rf_wnum  out  5  registered trace write register number.
REQ-017 debug_wb_rf_wdata  out  32  registered trace write data.

Function
REQ-018 Storage SHALL be 32 x 32-bit GPRs plus 32-bit HI and LO registers.
REQ-019 GPR write SHALL occur on posedge clk when wb_reg_write_en=1, rst=0 and wb_reg_write_addr!=0.
REQ-020 Writes to address 0 SHALL be discarded; GPR 0 SHALL always read 0.
REQ-021 HI and LO SHALL both load on posedge clk when wb_hilo_write_en=1 and rst=0; no partial write.
REQ-022 Read port n SHALL output 0 when rst=1, when regn_read_en=0, or when regn_read_addr=0.
REQ-023 Read port n SHALL output wb_reg_write_data (write-through bypass) when wb_reg_write_en=1 and wb_reg_write_addr equals regn_read_addr (nonzero). Rule REQ-022 has priority.
REQ-024 Otherwise read port n SHALL output the stored GPR value; read latency 0 cycles.
REQ-025 Both read ports SHALL operate independently; the same address on both ports SHALL yield identical data.
REQ-026 hi_read_data/lo_read_data SHALL output 0 during rst, wb_hi/lo_write_data when wb_hilo_write_en=1, else the stored HI/LO.
REQ-027 commit_cnt SHALL increment by 1 on every cycle that satisfies REQ-019, wrapping from 2^CNT_WIDTH-1 to 0; writes to r0 SHALL NOT count.
REQ-028 Trace outputs SHALL register one cycle after each input cycle: debug_wb_rf_wen = {4{REQ-019 condition}}, wnum = wb_reg_write_addr, wdata = wb_reg_write_data; when the condition is false, wen=4'b0000 and wnum/wdata SHALL hold their previous values.
REQ-029 Simultaneous GPR and HI/LO writes in the same cycle SHALL both take effect.
REQ-030 The block SHALL have no stall or backpressure; every enabled write commits in the cycle it is presented.

Reset
REQ-031 While rst=1 at posedge clk, all GPRs, HI, LO, commit_cnt, debug_wb_rf_wen, wnum and wdata SHALL become 0.
REQ-032 A write presented in a cycle with rst=1 SHALL be dropped and SHALL NOT be counted.
REQ-033 Reset asserted in the middle of a write stream SHALL clear all state at that edge; writes after deassertion SHALL behave as from power-up.

Verification
REQ-034 Reset for 2 cycles, then read r1..r31 on both ports -> all read 0; commit_cnt=0; HI=LO=0.
REQ-035 Write r5=0xDEADBEEF; the next cycle, read r5 -> 0xDEADBEEF; commit_cnt=1; debug_wb_rf_wen=4'hF, wnum=5, wdata=0xDEADBEEF one cycle after the write.
REQ-036 Write r7=0x12345678 and, in the same cycle, read r7 on port 1 and r8 on port 2 -> port1=0x12345678 (bypass), port2=0; with reg1_read_en=0 -> port1=0.
REQ-037 Write r0=0xFFFFFFFF -> read r0=0 in the same cycle and the next; commit_cnt unchanged; debug_wb_rf_wen=0.
REQ-038 hilo write HI=0xAAAA0000, LO=0x0000BBBB -> same-cycle hi/lo_read_data show the bypassed values, which persist afterwards; a simultaneous GPR write to r3 is also committed.
REQ-039 With CNT_WIDTH=4: 16 writes to r1 -> commit_cnt wraps to 0; then assert rst during a write to r2 -> r2 reads 0 and commit_cnt=0.
